// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debouncer bank.
// Channel states and a width helper that never returns zero bits.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        REL_PEND
    } ch_state_e;

    // $clog2 gives 0 for values <= 1, which would make a zero-width vector
    function automatic int width_of(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, polarity normalisation and a
// tick-qualified acceptance FSM producing a level plus press/release pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic state,
    output logic press,
    output logic rel
);

    localparam int             CW       = width_of(STABLE_TICKS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS);
    localparam logic           IDLE_LVL = ACTIVE_LOW;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;

    ch_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   press_d, rel_d, level_d;

    // Reset parks the chain at the idle pin level so no false press appears
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign lvl     = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (tick) begin
            case (state_q)
                RELEASED: begin
                    if (lvl) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = PRESSED;
                            press_d = 1'b1;
                        end else begin
                            state_d = PRESS_PEND;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!lvl) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!lvl) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = RELEASED;
                            rel_d   = 1'b1;
                        end else begin
                            state_d = REL_PEND;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                REL_PEND: begin
                    if (lvl) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign level_d = (state_d == PRESSED) || (state_d == REL_PEND);

    // Outputs are registered from the next state so the pulse lines up with the level edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            state   <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            state   <= level_d;
            press   <= press_d;
            rel     <= rel_d;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent button debouncers sharing one slow tick divider.
// The tick is registered and high for one clk cycle every TICK_DIV cycles.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_TICKS = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            tick
);

    localparam int            TW        = width_of(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt, tick_cnt_d;

    always_comb begin
        tick_cnt_d = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    end

    // tick tracks (tick_cnt == TICK_LAST) but stays low while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_d;
            tick     <= (tick_cnt_d == TICK_LAST);
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[ch]),
            .tick  (tick),
            .state (btn_state[ch]),
            .press (press_pulse[ch]),
            .rel   (release_pulse[ch])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: a per-cycle scoreboard fed by a
// run-length reference model, a phase table with hand-derived outcomes, and corner sequences.
module tb_debounce_bank;

    localparam int N_CH         = 2;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam bit ACTIVE_LOW   = 1'b1;
    localparam int SYNC_STAGES  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn_raw = '1;
    logic [N_CH-1:0] btn_state, press_pulse, release_pulse;
    logic            tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH         (N_CH),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS),
        .ACTIVE_LOW   (ACTIVE_LOW),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_state     (btn_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .tick          (tick)
    );

    typedef struct {
        logic [N_CH-1:0] state;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] rel;
        logic            tick;
    } exp_t;

    exp_t exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: a channel flips after STABLE_TICKS consecutive disagreeing tick samples
    logic [N_CH-1:0] m_sync [SYNC_STAGES];
    int              m_tick_cnt;
    logic            m_tick;
    logic [N_CH-1:0] m_state;
    int              m_run [N_CH];
    int              m_ticks_seen = 0;

    always @(posedge clk) begin : model
        exp_t            e;
        logic [N_CH-1:0] lvl;
        e.press = '0;
        e.rel   = '0;
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) m_sync[s] = {N_CH{ACTIVE_LOW}};
            m_tick_cnt = 0;
            m_tick     = 1'b0;
            m_state    = '0;
            for (int c = 0; c < N_CH; c++) m_run[c] = 0;
        end else begin
            lvl = m_sync[SYNC_STAGES-1] ^ {N_CH{ACTIVE_LOW}};
            if (m_tick) begin
                m_ticks_seen++;
                for (int c = 0; c < N_CH; c++) begin
                    if (lvl[c] != m_state[c]) begin
                        m_run[c]++;
                        if (m_run[c] == STABLE_TICKS) begin
                            m_state[c] = lvl[c];
                            m_run[c]   = 0;
                            if (lvl[c]) e.press[c] = 1'b1;
                            else        e.rel[c]   = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
            for (int s = SYNC_STAGES - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
            m_sync[0]  = btn_raw;
            m_tick_cnt = (m_tick_cnt + 1) % TICK_DIV;
            m_tick     = (m_tick_cnt == TICK_DIV - 1);
        end
        e.state = m_state;
        e.tick  = m_tick;
        exp_q.push_back(e);
    end

    int n_press [N_CH] = '{default: 0};
    int n_rel   [N_CH] = '{default: 0};
    int n_hi    [N_CH] = '{default: 0};

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_btn_state", 32'(btn_state), 32'(e.state));
            checkOutput("sb_press_pulse", 32'(press_pulse), 32'(e.press));
            checkOutput("sb_release_pulse", 32'(release_pulse), 32'(e.rel));
            checkOutput("sb_tick", 32'(tick), 32'(e.tick));
            for (int c = 0; c < N_CH; c++) begin
                n_press[c] += int'(press_pulse[c]);
                n_rel[c]   += int'(release_pulse[c]);
                n_hi[c]    += int'(btn_state[c]);
            end
        end
    end

    typedef struct {
        logic            rst;
        logic [N_CH-1:0] raw;
        int              cycles;
        int              press0, rel0, press1, rel1;
        logic [N_CH-1:0] state;
    } vec_t;

    vec_t vecs [8];
    int   b_press [N_CH];
    int   b_rel   [N_CH];
    int   b_hi    [N_CH];

    // Called at posedge+1; returns at posedge+1 after the given number of clock edges
    task automatic applyStimulus(input logic r, input logic [N_CH-1:0] raw, input int cycles);
        rst     = r;
        btn_raw = raw;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic takeSnapshot();
        for (int c = 0; c < N_CH; c++) begin
            b_press[c] = n_press[c];
            b_rel[c]   = n_rel[c];
            b_hi[c]    = n_hi[c];
        end
    endtask

    initial begin : watchdog
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int lat;
        int t0;
        bit found;

        // Phases are long enough (24 > worst-case 15) that outcomes do not depend on tick phase
        vecs[0] = '{1'b1, 2'b11,  3, 0, 0, 0, 0, 2'b00};
        vecs[1] = '{1'b0, 2'b11, 20, 0, 0, 0, 0, 2'b00};
        vecs[2] = '{1'b0, 2'b10, 24, 1, 0, 0, 0, 2'b01};
        vecs[3] = '{1'b0, 2'b11, 24, 0, 1, 0, 0, 2'b00};
        vecs[4] = '{1'b0, 2'b00, 24, 1, 0, 1, 0, 2'b11};
        vecs[5] = '{1'b0, 2'b11, 24, 0, 1, 0, 1, 2'b00};
        vecs[6] = '{1'b0, 2'b01, 24, 0, 0, 1, 0, 2'b10};
        vecs[7] = '{1'b0, 2'b11, 24, 0, 0, 0, 1, 2'b00};

        $display("[TB] reset and tick phase");
        rst     = 1'b1;
        btn_raw = 2'b11;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_btn_state", 32'(btn_state), 32'h0);
        checkOutput("reset_pulses", 32'({press_pulse, release_pulse}), 32'h0);
        checkOutput("reset_tick", 32'(tick), 32'h0);
        rst = 1'b0;
        // The cycle in which rst drops counts as cycle 1, so ticks land on cycles 4, 8, 12
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("tick_cycle_%0d", k), 32'(tick), 32'((k % TICK_DIV) == 0));
        end
        @(posedge clk);
        #1;

        $display("[TB] phase table");
        for (int i = 0; i < 8; i++) begin
            takeSnapshot();
            applyStimulus(vecs[i].rst, vecs[i].raw, vecs[i].cycles);
            checkOutput($sformatf("vec%0d_press0", i), 32'(n_press[0] - b_press[0]), 32'(vecs[i].press0));
            checkOutput($sformatf("vec%0d_rel0", i),   32'(n_rel[0] - b_rel[0]),     32'(vecs[i].rel0));
            checkOutput($sformatf("vec%0d_press1", i), 32'(n_press[1] - b_press[1]), 32'(vecs[i].press1));
            checkOutput($sformatf("vec%0d_rel1", i),   32'(n_rel[1] - b_rel[1]),     32'(vecs[i].rel1));
            checkOutput($sformatf("vec%0d_state", i),  32'(btn_state),               32'(vecs[i].state));
        end

        $display("[TB] clean press latency");
        btn_raw = 2'b10;
        lat     = 0;
        found   = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (btn_state[0]) begin
                lat   = k;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checkOutput("press_timeout", 32'(found), 32'h1);
        end else begin
            // Sample k sits after k-1 edges; the first edge captures the drive, so k-2 edges elapsed
            checkOutput("press_latency_window", 32'((lat - 2 >= 9) && (lat - 2 <= 13)), 32'h1);
            checkOutput("press_pulse_with_level", 32'(press_pulse), 32'b01);
            checkOutput("press_ch1_idle", 32'(btn_state[1]), 32'h0);
            @(negedge clk);
            checkOutput("press_pulse_one_cycle", 32'(press_pulse), 32'h0);
        end
        @(posedge clk);
        #1;

        $display("[TB] release");
        takeSnapshot();
        applyStimulus(1'b0, 2'b11, 24);
        checkOutput("release_count", 32'(n_rel[0] - b_rel[0]), 32'h1);
        checkOutput("release_no_press", 32'(n_press[0] - b_press[0]), 32'h0);
        checkOutput("release_state", 32'(btn_state), 32'h0);

        $display("[TB] bounce rejection");
        takeSnapshot();
        // 8 low cycles cover exactly two tick samples, 4 high cycles exactly one
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, 2'b10, 8);
            applyStimulus(1'b0, 2'b11, 4);
        end
        applyStimulus(1'b0, 2'b11, 16);
        checkOutput("bounce_press", 32'(n_press[0] - b_press[0]), 32'h0);
        checkOutput("bounce_release", 32'(n_rel[0] - b_rel[0]), 32'h0);
        checkOutput("bounce_level_cycles", 32'(n_hi[0] - b_hi[0]), 32'h0);

        $display("[TB] simultaneous channels");
        btn_raw = 2'b00;
        found   = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (press_pulse != '0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("simul_seen", 32'(found), 32'h1);
        checkOutput("simul_press", 32'(press_pulse), 32'b11);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b00, 8);
        applyStimulus(1'b0, 2'b11, 24);

        $display("[TB] reset while pending");
        takeSnapshot();
        btn_raw = 2'b10;
        found   = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (m_run[0] == 2) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("pending_reached", 32'(found), 32'h1);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 2'b10, 2);
        checkOutput("pending_no_pulse", 32'(n_press[0] - b_press[0]), 32'h0);
        checkOutput("pending_reset_state", 32'(btn_state), 32'h0);
        rst = 1'b0;
        t0  = m_ticks_seen;
        takeSnapshot();
        found = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (press_pulse[0]) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reaccept_seen", 32'(found), 32'h1);
        checkOutput("reaccept_ticks", 32'(m_ticks_seen - t0), 32'd3);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b10, 20);
        checkOutput("reaccept_once", 32'(n_press[0] - b_press[0]), 32'h1);
        checkOutput("reaccept_state", 32'(btn_state), 32'b01);

        applyStimulus(1'b0, 2'b11, 24);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
